vga_sync: RTL and testbench

Raster timing generator for the 640x480 @ 60 Hz display path. Clocked directly by the 25 MHz pixel clock from the clock divider. Produces horizontal/vertical counters, active-low sync pulses, a visible-area flag, line/frame strobes and a free-running frame counter. The renderer and game-object logic use these to choose pixel colour and to pace per-frame motion.

---
 rtl/vga_sync_if.sv | 25 ++
 rtl/vga_sync.sv | 141 ++++++++++++++
 tb/tb_vga_sync.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/vga_sync_if.sv
// Raster timing bundle produced by vga_sync.
//   hc/vc      : current pixel/line position
//   hsync/vsync: active-low sync pulses
//   video_on   : pixel is inside the visible area
//   line_end   : last pixel of a line
//   frame_end  : last pixel of a frame
//   frame_cnt  : frames completed since reset, wraps mod 256
interface vga_sync_if;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_end;
  logic       frame_end;
  logic [7:0] frame_cnt;

  modport master (
    output hc, vc, hsync, vsync, video_on, line_end, frame_end, frame_cnt
  );

  modport slave (
    input hc, vc, hsync, vsync, video_on, line_end, frame_end, frame_cnt
  );
endinterface

// File: rtl/vga_sync.sv
// Raster timing generator for 640x480 @ 60 Hz, clocked by the pixel clock.
// Ports:
//   clk : pixel clock
//   rst : synchronous active-low reset
//   vga : vga_sync_if.master, all fields registered
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
module vga_sync #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic        clk,
  input  logic        rst,
  vga_sync_if.master  vga
);

  localparam int unsigned CW      = 10;
  localparam int unsigned FW      = 8;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_FP_START = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SY_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_BP_START = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_FP_START = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SY_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_BP_START = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } region_e;

  region_e       h_state_q, h_state_d;
  region_e       v_state_q, v_state_d;
  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          video_on_q, video_on_d;
  logic          line_end_q, line_end_d;
  logic          frame_end_q, frame_end_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          h_wrap;

  // Region state registers; reset parks both FSMs in back porch at the terminal position.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_state_q <= ST_BACK;
      v_state_q <= ST_BACK;
    end else begin
      h_state_q <= h_state_d;
      v_state_q <= v_state_d;
    end
  end

  // Next counters and next region; regions advance when the next count hits a boundary.
  always_comb begin
    h_state_d = h_state_q;
    v_state_d = v_state_q;
    h_wrap    = (hc_q == H_LAST);
    hc_d      = h_wrap ? '0 : CW'(hc_q + CW'(1));
    vc_d      = vc_q;
    if (h_wrap) begin
      vc_d = (vc_q == V_LAST) ? '0 : CW'(vc_q + CW'(1));
    end

    case (h_state_q)
      ST_ACTIVE: if (hc_d == H_FP_START) h_state_d = ST_FRONT;
      ST_FRONT:  if (hc_d == H_SY_START) h_state_d = ST_SYNC;
      ST_SYNC:   if (hc_d == H_BP_START) h_state_d = ST_BACK;
      ST_BACK:   if (hc_d == '0)         h_state_d = ST_ACTIVE;
      default:                           h_state_d = ST_BACK;
    endcase

    // Vertical region can only move on a line wrap, so vsync changes only with vc.
    if (h_wrap) begin
      case (v_state_q)
        ST_ACTIVE: if (vc_d == V_FP_START) v_state_d = ST_FRONT;
        ST_FRONT:  if (vc_d == V_SY_START) v_state_d = ST_SYNC;
        ST_SYNC:   if (vc_d == V_BP_START) v_state_d = ST_BACK;
        ST_BACK:   if (vc_d == '0)         v_state_d = ST_ACTIVE;
        default:                           v_state_d = ST_BACK;
      endcase
    end
  end

  // Flags decoded from the next position so they line up with the registered hc/vc.
  always_comb begin
    hsync_d     = (h_state_d != ST_SYNC);
    vsync_d     = (v_state_d != ST_SYNC);
    video_on_d  = (h_state_d == ST_ACTIVE) && (v_state_d == ST_ACTIVE);
    line_end_d  = (hc_d == H_LAST);
    frame_end_d = line_end_d && (vc_d == V_LAST);
    // A frame completes on the edge leaving the frame_end pixel; reset clears frame_end_q,
    // so leaving reset at the terminal position is not counted.
    frame_cnt_d = frame_end_q ? FW'(frame_cnt_q + FW'(1)) : frame_cnt_q;
  end

  // Counter and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      hc_q        <= H_LAST;
      vc_q        <= V_LAST;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      video_on_q  <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      video_on_q  <= video_on_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign vga.hc        = hc_q;
  assign vga.vc        = vc_q;
  assign vga.hsync     = hsync_q;
  assign vga.vsync     = vsync_q;
  assign vga.video_on  = video_on_q;
  assign vga.line_end  = line_end_q;
  assign vga.frame_end = frame_end_q;
  assign vga.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync. Instance A keeps full horizontal timing with a short
// 19-line frame (12/2/2/3) so vertical behaviour fits the run; instance B is a
// tiny 8x6 raster used for mid-frame reset and frame counter wrap.
module tb_vga_sync;

  logic clk = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;

  always #5 clk = ~clk;

  vga_sync_if if_a ();
  vga_sync_if if_b ();

  vga_sync #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(12),  .V_FP(2),  .V_SYNC(2),  .V_BP(3)
  ) dut_a (
    .clk (clk),
    .rst (rst_a),
    .vga (if_a.master)
  );

  vga_sync #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .clk (clk),
    .rst (rst_b),
    .vga (if_b.master)
  );

  typedef struct {
    int         n;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs;
    logic       vs;
    logic       von;
    logic       le;
    logic       fe;
    logic [7:0] fc;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input vec_t v);
    check({tag, ".hc"},        32'(if_a.hc),        32'(v.hc));
    check({tag, ".vc"},        32'(if_a.vc),        32'(v.vc));
    check({tag, ".hsync"},     32'(if_a.hsync),     32'(v.hs));
    check({tag, ".vsync"},     32'(if_a.vsync),     32'(v.vs));
    check({tag, ".video_on"},  32'(if_a.video_on),  32'(v.von));
    check({tag, ".line_end"},  32'(if_a.line_end),  32'(v.le));
    check({tag, ".frame_end"}, 32'(if_a.frame_end), 32'(v.fe));
    check({tag, ".frame_cnt"}, 32'(if_a.frame_cnt), 32'(v.fc));
  endtask

  task automatic check_b(input string tag, input vec_t v);
    check({tag, ".hc"},        32'(if_b.hc),        32'(v.hc));
    check({tag, ".vc"},        32'(if_b.vc),        32'(v.vc));
    check({tag, ".hsync"},     32'(if_b.hsync),     32'(v.hs));
    check({tag, ".vsync"},     32'(if_b.vsync),     32'(v.vs));
    check({tag, ".video_on"},  32'(if_b.video_on),  32'(v.von));
    check({tag, ".line_end"},  32'(if_b.line_end),  32'(v.le));
    check({tag, ".frame_end"}, 32'(if_b.frame_end), 32'(v.fe));
    check({tag, ".frame_cnt"}, 32'(if_b.frame_cnt), 32'(v.fc));
  endtask

  initial begin
    int   cur;
    int   vs_low;
    int   le_cnt;
    int   fe_cnt;
    vec_t r;

    // n = clocks since the first post-reset pixel (hc=0, vc=0); hc = n%800, vc = n/800.
    //            n      hc   vc  hs vs von le fe fc
    vecs[0]  = '{0,     0,   0,  1, 1, 1, 0, 0, 0};
    vecs[1]  = '{639,   639, 0,  1, 1, 1, 0, 0, 0};
    vecs[2]  = '{640,   640, 0,  1, 1, 0, 0, 0, 0};
    vecs[3]  = '{655,   655, 0,  1, 1, 0, 0, 0, 0};
    vecs[4]  = '{656,   656, 0,  0, 1, 0, 0, 0, 0};
    vecs[5]  = '{751,   751, 0,  0, 1, 0, 0, 0, 0};
    vecs[6]  = '{752,   752, 0,  1, 1, 0, 0, 0, 0};
    vecs[7]  = '{799,   799, 0,  1, 1, 0, 1, 0, 0};
    vecs[8]  = '{800,   0,   1,  1, 1, 1, 0, 0, 0};
    vecs[9]  = '{8799,  799, 10, 1, 1, 0, 1, 0, 0};
    vecs[10] = '{8800,  0,   11, 1, 1, 1, 0, 0, 0};
    vecs[11] = '{9599,  799, 11, 1, 1, 0, 1, 0, 0};
    vecs[12] = '{9600,  0,   12, 1, 1, 0, 0, 0, 0};
    vecs[13] = '{10400, 0,   13, 1, 1, 0, 0, 0, 0};
    vecs[14] = '{11199, 799, 13, 1, 1, 0, 1, 0, 0};
    vecs[15] = '{11200, 0,   14, 1, 0, 0, 0, 0, 0};
    vecs[16] = '{11856, 656, 14, 0, 0, 0, 0, 0, 0};
    vecs[17] = '{12799, 799, 15, 1, 0, 0, 1, 0, 0};
    vecs[18] = '{12800, 0,   16, 1, 1, 0, 0, 0, 0};
    vecs[19] = '{15199, 799, 18, 1, 1, 0, 1, 1, 0};
    vecs[20] = '{15200, 0,   0,  1, 1, 1, 0, 0, 1};

    // Reset held for three clocks: terminal counters, strobes forced low.
    step(3);
    check_a("a_reset", '{0, 799, 18, 1, 1, 0, 0, 0, 0});
    check_b("b_reset", '{0, 7, 5, 1, 1, 0, 0, 0, 0});

    rst_a = 1'b1;
    step(1);
    cur = 0;
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].n > cur) begin
        step(vecs[i].n - cur);
        cur = vecs[i].n;
      end
      check_a($sformatf("a_vec%0d", i), vecs[i]);
    end

    // One full frame starting at (0,0): sync-low and strobe occupancy.
    vs_low = 0;
    le_cnt = 0;
    fe_cnt = 0;
    for (int i = 0; i < 15200; i++) begin
      if (if_a.vsync == 1'b0) vs_low++;
      if (if_a.line_end) le_cnt++;
      if (if_a.frame_end) fe_cnt++;
      step(1);
    end
    check("a_vsync_low_clocks", 32'(vs_low), 32'd1600);
    check("a_line_end_count",   32'(le_cnt), 32'd19);
    check("a_frame_end_count",  32'(fe_cnt), 32'd1);
    check_a("a_frame2", '{0, 0, 0, 1, 1, 1, 0, 0, 2});

    // Instance B: 48 clocks per frame.
    rst_b = 1'b1;
    step(1);
    check_b("b_first", '{0, 0, 0, 1, 1, 1, 0, 0, 0});
    step(5 * 48 + 2 * 8 + 3);
    check_b("b_mid", '{0, 3, 2, 1, 1, 1, 0, 0, 5});

    // Mid-frame reset jumps straight to the terminal position with frame_cnt cleared.
    rst_b = 1'b0;
    step(1);
    check_b("b_midreset", '{0, 7, 5, 1, 1, 0, 0, 0, 0});
    rst_b = 1'b1;
    step(1);
    check_b("b_release", '{0, 0, 0, 1, 1, 1, 0, 0, 0});

    // 256 frames: last pixel before wrap, then the counter returns to 0.
    step(256 * 48 - 1);
    r = '{0, 7, 5, 1, 1, 0, 1, 1, 255};
    check_b("b_frame255_end", r);
    step(1);
    check_b("b_frame_wrap", '{0, 0, 0, 1, 1, 1, 0, 0, 0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
